// File: rtl/hazard5_bus_pkg.sv
// Shared AHB-Lite encodings and data-phase monitor state constants.
package hazard5_bus_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HSIZE encodings
  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  // Data-phase FSM states
  typedef logic [1:0] dph_state_t;
  localparam dph_state_t DPH_IDLE   = 2'd0;
  localparam dph_state_t DPH_ACTIVE = 2'd1;
  localparam dph_state_t DPH_ERR1   = 2'd2;

  // Unshifted byte-lane mask for a transfer size; unknown sizes touch no lanes.
  function automatic logic [7:0] size_lane_mask(input logic [2:0] hsize);
    logic [7:0] m;
    case (hsize)
      HSIZE_BYTE:  m = 8'h01;
      HSIZE_HALF:  m = 8'h03;
      HSIZE_WORD:  m = 8'h0F;
      HSIZE_DWORD: m = 8'hFF;
      default:     m = 8'h00;
    endcase
    return m;
  endfunction

  // True when the low address bits are not a multiple of the transfer size.
  function automatic logic addr_misaligned(input logic [2:0] hsize, input logic [2:0] addr_lo);
    logic mis;
    case (hsize)
      HSIZE_HALF:  mis = addr_lo[0];
      HSIZE_WORD:  mis = |addr_lo[1:0];
      HSIZE_DWORD: mis = |addr_lo[2:0];
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rvfi_rec_fifo.sv
// Show-ahead record FIFO: head entry is visible combinationally, zero when empty.
module rvfi_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  // A pop on an empty FIFO is ignored; a push when full only lands if a pop frees a slot.
  always_comb begin
    w_empty   = (r_count == {(AW+1){1'b0}});
    w_full    = (r_count == (AW+1)'(DEPTH));
    w_do_pop  = i_pop & ~w_empty;
    w_do_push = i_push & (~w_full | w_do_pop);
    o_drop    = i_push & w_full & ~w_do_pop;
    o_valid   = ~w_empty;
    if (w_empty) begin
      o_data = {WIDTH{1'b0}};
    end else begin
      o_data = r_mem[r_rptr];
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/ahbl_rvfi_mem_monitor.sv
// Passive AHB-Lite monitor that turns tagged load/store transfers into
// RVFI-style memory records queued in a show-ahead FIFO, with sticky fault flags.
module ahbl_rvfi_mem_monitor
  import hazard5_bus_pkg::*;
#(
  parameter int W_ADDR   = 32,
  parameter int W_DATA   = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [W_ADDR-1:0]   haddr,
  input  logic                hwrite,
  input  logic [1:0]          htrans,
  input  logic [2:0]          hsize,
  input  logic                hready,
  input  logic                hresp,
  input  logic [W_DATA-1:0]   hwdata,
  input  logic [W_DATA-1:0]   hrdata,
  input  logic                tag,
  output logic                rec_valid,
  output logic [W_ADDR-1:0]   rec_addr,
  output logic [W_DATA/8-1:0] rec_rmask,
  output logic [W_DATA/8-1:0] rec_wmask,
  output logic [W_DATA-1:0]   rec_rdata,
  output logic [W_DATA-1:0]   rec_wdata,
  output logic                rec_err,
  input  logic                rec_pop,
  output logic                overflow,
  output logic                stall_timeout,
  output logic                proto_err
);

  localparam int NB    = W_DATA / 8;
  localparam int OFFS  = $clog2(NB);
  localparam int WW    = $clog2(MAX_WAIT + 1);
  localparam int REC_W = 1 + W_ADDR + 2 * NB + 2 * W_DATA;

  // Data-phase copy of the address phase
  logic [W_ADDR-1:0] r_dph_addr;
  logic              r_dph_write;
  logic [2:0]        r_dph_size;
  logic              r_dph_active;
  dph_state_t        r_state;
  logic [WW-1:0]     r_wait;
  logic              r_overflow;
  logic              r_stall_timeout;
  logic              r_proto_err;

  logic              w_addr_active;
  logic [NB-1:0]     w_byte_mask;
  logic              w_push;
  logic              w_err;
  logic [W_ADDR-1:0] w_addr;
  logic [NB-1:0]     w_rmask;
  logic [NB-1:0]     w_wmask;
  logic [W_DATA-1:0] w_rdata;
  logic [W_DATA-1:0] w_wdata;
  logic [WW-1:0]     w_wait_next;
  logic              w_proto;
  logic              w_fifo_valid;
  logic [REC_W-1:0]  w_fifo_head;
  logic              w_fifo_drop;

  // Record contents for the current data phase plus wait/fault evaluation.
  always_comb begin
    w_addr_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    // Truncating before the lane shift gives the same low bits as truncating after.
    w_byte_mask   = NB'(size_lane_mask(r_dph_size)) << r_dph_addr[OFFS-1:0];
    w_push        = hready & r_dph_active & (r_state != DPH_IDLE);
    w_err         = (r_state == DPH_ERR1) & hresp;
    w_addr        = {r_dph_addr[W_ADDR-1:OFFS], {OFFS{1'b0}}};
    w_rmask       = {NB{1'b0}};
    w_wmask       = {NB{1'b0}};
    w_rdata       = {W_DATA{1'b0}};
    w_wdata       = {W_DATA{1'b0}};
    if (r_dph_write) begin
      w_wdata = hwdata;
      if (!w_err) w_wmask = w_byte_mask;
      else        w_wmask = {NB{1'b0}};
    end else begin
      w_rdata = hrdata;
      if (!w_err) w_rmask = w_byte_mask;
      else        w_rmask = {NB{1'b0}};
    end
    if (hready) begin
      w_wait_next = {WW{1'b0}};
    end else if ((r_state != DPH_IDLE) && (r_wait != WW'(MAX_WAIT))) begin
      w_wait_next = r_wait + WW'(1);
    end else begin
      w_wait_next = r_wait;
    end
    w_proto = (~hready & (r_state == DPH_IDLE))
            | (hready & hresp & (r_state != DPH_ERR1))
            | (hready & w_addr_active & (((W_DATA == 32) && (hsize == HSIZE_DWORD))
                                         | addr_misaligned(hsize, haddr[2:0])));
  end

  // Capture the address phase whenever the bus advances.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dph_addr   <= {W_ADDR{1'b0}};
      r_dph_write  <= 1'b0;
      r_dph_size   <= 3'd0;
      r_dph_active <= 1'b0;
    end else if (hready) begin
      r_dph_addr   <= haddr;
      r_dph_write  <= hwrite;
      r_dph_size   <= hsize;
      r_dph_active <= w_addr_active & tag;
    end
  end

  // Data-phase FSM: follows the bus on hready, notes the first error cycle otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= DPH_IDLE;
    end else if (hready) begin
      r_state <= (w_addr_active & tag) ? DPH_ACTIVE : DPH_IDLE;
    end else if ((r_state == DPH_ACTIVE) && hresp) begin
      r_state <= DPH_ERR1;
    end
  end

  // Wait counter and sticky status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait          <= {WW{1'b0}};
      r_overflow      <= 1'b0;
      r_stall_timeout <= 1'b0;
      r_proto_err     <= 1'b0;
    end else begin
      r_wait <= w_wait_next;
      if (w_fifo_drop) r_overflow <= 1'b1;
      if (w_wait_next == WW'(MAX_WAIT)) r_stall_timeout <= 1'b1;
      if (w_proto) r_proto_err <= 1'b1;
    end
  end

  rvfi_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  ({w_err, w_addr, w_rmask, w_wmask, w_rdata, w_wdata}),
    .i_pop   (rec_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_head),
    .o_drop  (w_fifo_drop)
  );

  assign rec_valid = w_fifo_valid;
  assign {rec_err, rec_addr, rec_rmask, rec_wmask, rec_rdata, rec_wdata} = w_fifo_head;
  assign overflow      = r_overflow;
  assign stall_timeout = r_stall_timeout;
  assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_ahbl_rvfi_mem_monitor.sv
// Bench: a 32-bit and a 64-bit monitor watch the same directed AHB-Lite traffic;
// a transfer-level scoreboard predicts the FIFO contents and flags for each.
module tb_ahbl_rvfi_mem_monitor;
  import hazard5_bus_pkg::*;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] haddr;
  logic        hwrite, hready, hresp, tag, rec_pop;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [63:0] hwdata, hrdata;

  logic        v32, e32, ovf32, st32, pe32;
  logic [31:0] a32, rd32, wd32;
  logic [3:0]  rm32, wm32;
  logic        v64, e64, ovf64, st64, pe64;
  logic [31:0] a64;
  logic [63:0] rd64, wd64;
  logic [7:0]  rm64, wm64;

  ahbl_rvfi_mem_monitor #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut32 (
    .clock(clk), .reset(rst), .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
    .hready(hready), .hresp(hresp), .hwdata(hwdata[31:0]), .hrdata(hrdata[31:0]), .tag(tag),
    .rec_valid(v32), .rec_addr(a32), .rec_rmask(rm32), .rec_wmask(wm32), .rec_rdata(rd32),
    .rec_wdata(wd32), .rec_err(e32), .rec_pop(rec_pop), .overflow(ovf32),
    .stall_timeout(st32), .proto_err(pe32));

  ahbl_rvfi_mem_monitor #(.W_ADDR(32), .W_DATA(64), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut64 (
    .clock(clk), .reset(rst), .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
    .hready(hready), .hresp(hresp), .hwdata(hwdata), .hrdata(hrdata), .tag(tag),
    .rec_valid(v64), .rec_addr(a64), .rec_rmask(rm64), .rec_wmask(wm64), .rec_rdata(rd64),
    .rec_wdata(wd64), .rec_err(e64), .rec_pop(rec_pop), .overflow(ovf64),
    .stall_timeout(st64), .proto_err(pe64));

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  rmask;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic [63:0] wdata;
    logic        err;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t q32[$];
  rec_t q64[$];
  bit   m_push = 1'b0;
  bit   m_pop  = 1'b0;
  rec_t m_rec32, m_rec64;
  bit   exp_ovf = 1'b0;
  bit   exp_stall = 1'b0;
  bit   exp_pe32 = 1'b0;
  bit   exp_pe64 = 1'b0;
  bit   run = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected record of one completed transfer, from lane arithmetic on a bus of nb bytes.
  function automatic rec_t mk(input int nb, input logic [31:0] a, input bit wr, input int sz,
                              input logic [63:0] dat, input bit err);
    rec_t r;
    int nbytes = 1 << sz;
    int off = int'(a % nb);
    logic [15:0] m;
    logic [63:0] dmask;
    m = ((16'd1 << nbytes) - 16'd1) << off;
    m = m & ((16'd1 << nb) - 16'd1);
    if (err) m = 16'd0;
    dmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    r.addr  = 64'(a) - 64'(off);
    r.rmask = wr ? 8'h00 : m[7:0];
    r.wmask = wr ? m[7:0] : 8'h00;
    r.rdata = wr ? 64'h0 : (dat & dmask);
    r.wdata = wr ? (dat & dmask) : 64'h0;
    r.err   = err;
    return r;
  endfunction

  // Scoreboard: pops only from a non-empty queue, drops a push that finds no room.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q32.delete();
      q64.delete();
      exp_ovf <= 1'b0;
    end else begin
      if (m_pop && q32.size() != 0) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (m_push) begin
        if (q32.size() < DEPTH) begin
          q32.push_back(m_rec32);
          q64.push_back(m_rec64);
        end else begin
          exp_ovf <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of both monitors against the scoreboard.
  always @(negedge clk) begin
    rec_t e3, e6;
    if (run) begin
      e3 = (q32.size() != 0) ? q32[0] : rec_t'(0);
      e6 = (q64.size() != 0) ? q64[0] : rec_t'(0);
      chk("valid32", 64'(v32), 64'(q32.size() != 0));
      chk("addr32", 64'(a32), e3.addr);
      chk("rmask32", 64'(rm32), 64'(e3.rmask));
      chk("wmask32", 64'(wm32), 64'(e3.wmask));
      chk("rdata32", 64'(rd32), e3.rdata);
      chk("wdata32", 64'(wd32), e3.wdata);
      chk("err32", 64'(e32), 64'(e3.err));
      chk("ovf32", 64'(ovf32), 64'(exp_ovf));
      chk("stall32", 64'(st32), 64'(exp_stall));
      chk("proto32", 64'(pe32), 64'(exp_pe32));
      chk("valid64", 64'(v64), 64'(q64.size() != 0));
      chk("addr64", 64'(a64), e6.addr);
      chk("rmask64", 64'(rm64), 64'(e6.rmask));
      chk("wmask64", 64'(wm64), 64'(e6.wmask));
      chk("rdata64", rd64, e6.rdata);
      chk("wdata64", wd64, e6.wdata);
      chk("err64", 64'(e64), 64'(e6.err));
      chk("ovf64", 64'(ovf64), 64'(exp_ovf));
      chk("stall64", 64'(st64), 64'(exp_stall));
      chk("proto64", 64'(pe64), 64'(exp_pe64));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0; tag = 1'b0;
    hready = 1'b1; hresp = 1'b0; rec_pop = 1'b0; m_push = 1'b0; m_pop = 1'b0;
  endtask

  // One transfer. mode 0: OKAY; 1: two-cycle ERROR (nwait>=1); 2: lone hresp on the ready cycle.
  task automatic xfer(input logic [31:0] a, input bit wr, input int sz, input bit tg,
                      input int nwait, input int mode, input logic [63:0] dat, input bit pop_fin);
    htrans = 2'b10; haddr = a; hwrite = wr; hsize = 3'(sz); tag = tg;
    hready = 1'b1; hresp = 1'b0; rec_pop = 1'b0; m_push = 1'b0; m_pop = 1'b0;
    cyc();
    if ((a % (32'd1 << sz)) != 32'd0) begin exp_pe32 = 1'b1; exp_pe64 = 1'b1; end
    if (sz == 3) exp_pe32 = 1'b1;
    htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0; tag = 1'b0;
    hrdata = 64'hBAD0_BAD1_BAD2_BAD3; hwdata = 64'hBAD4_BAD5_BAD6_BAD7;
    for (int i = 0; i < nwait; i++) begin
      hready = 1'b0;
      hresp  = (mode == 1) && (i == nwait - 1);
      cyc();
      if (i + 1 >= MAX_WAIT) exp_stall = 1'b1;
    end
    hready = 1'b1; hresp = (mode != 0); hrdata = dat; hwdata = dat;
    rec_pop = pop_fin; m_pop = pop_fin; m_push = tg;
    m_rec32 = mk(4, a, wr, sz, dat, mode == 1);
    m_rec64 = mk(8, a, wr, sz, dat, mode == 1);
    cyc();
    if (mode == 2) begin exp_pe32 = 1'b1; exp_pe64 = 1'b1; end
    idle_bus();
  endtask

  task automatic pop_one();
    rec_pop = 1'b1; m_pop = 1'b1;
    cyc();
    rec_pop = 1'b0; m_pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; exp_stall = 1'b0; exp_pe32 = 1'b0; exp_pe64 = 1'b0;
    idle_bus();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    idle_bus();
    hrdata = 64'h0; hwdata = 64'h0;
    cyc();
    cyc();
    run = 1'b1;
    chk("rst_valid32", 64'(v32), 64'd0);
    chk("rst_state32", 64'(dut32.r_state), 64'(DPH_IDLE));
    chk("rst_flags64", {61'd0, ovf64, st64, pe64}, 64'd0);
    rst = 1'b0;
    cyc();

    // 32-bit halfword read with one wait state
    xfer(32'h1002, 1'b0, 1, 1'b1, 1, 0, 64'h1122_3344_A1B2_C3D4, 1'b0);
    chk("rd_addr32", 64'(a32), 64'h1000);
    chk("rd_rmask32", 64'(rm32), 64'hC);
    chk("rd_rdata32", 64'(rd32), 64'hA1B2_C3D4);
    chk("rd_rmask64", 64'(rm64), 64'h0C);
    pop_one();

    // word write in the upper half of a 64-bit bus
    xfer(32'h2004, 1'b1, 2, 1'b1, 0, 0, 64'h5566_7788_99AA_BBCC, 1'b0);
    chk("wr_wmask64", 64'(wm64), 64'hF0);
    chk("wr_addr64", 64'(a64), 64'h2000);
    chk("wr_wdata64", wd64, 64'h5566_7788_99AA_BBCC);
    chk("wr_wmask32", 64'(wm32), 64'hF);
    pop_one();

    // untagged fetch leaves no record
    xfer(32'h0000_0100, 1'b0, 2, 1'b0, 0, 0, 64'h0123_4567_89AB_CDEF, 1'b0);
    chk("fetch_none", 64'(v32), 64'd0);

    // timeout boundary: 15 waits stay quiet, 16 waits raise the flag
    xfer(32'h4000, 1'b0, 2, 1'b1, 15, 0, 64'h0000_0000_0000_4015, 1'b1);
    chk("stall15", 64'(st32), 64'd0);
    pop_one();
    xfer(32'h4004, 1'b0, 2, 1'b1, 16, 0, 64'h0000_0000_0000_4016, 1'b0);
    chk("stall16", 64'(st32), 64'd1);
    pop_one();
    do_reset();

    // overflow: five pushes into four slots with no pop
    for (int i = 0; i < 5; i++)
      xfer(32'h100 + 32'(i * 4), 1'b0, 2, 1'b1, 0, 0, 64'(i + 1), 1'b0);
    chk("ovf_set", 64'(ovf32), 64'd1);
    chk("ovf_head", 64'(rd32), 64'd1);
    for (int i = 0; i < 4; i++) pop_one();
    chk("ovf_drained", 64'(v32), 64'd0);
    do_reset();

    // pop on the fifth push cycle makes room
    for (int i = 0; i < 5; i++)
      xfer(32'h100 + 32'(i * 4), 1'b0, 2, 1'b1, 0, 0, 64'(i + 11), i == 4);
    chk("ovf_clear", 64'(ovf32), 64'd0);
    chk("ovf_head2", 64'(rd32), 64'd12);
    for (int i = 0; i < 4; i++) pop_one();

    // two-cycle error response, then a lone hresp
    xfer(32'h5008, 1'b1, 2, 1'b1, 2, 1, 64'h0000_0000_E000_0001, 1'b0);
    chk("err_flag", 64'(e32), 64'd1);
    chk("err_wmask", 64'(wm32), 64'd0);
    chk("err_noproto", 64'(pe32), 64'd0);
    pop_one();
    xfer(32'h500C, 1'b0, 2, 1'b1, 0, 2, 64'h0000_0000_E000_0002, 1'b0);
    chk("lone_resp", 64'(pe32), 64'd1);
    pop_one();
    do_reset();

    // illegal size on the narrow bus and a misaligned word
    xfer(32'h3000, 1'b0, 3, 1'b1, 0, 0, 64'hFEDC_BA98_7654_3210, 1'b0);
    chk("dw_proto32", 64'(pe32), 64'd1);
    chk("dw_proto64", 64'(pe64), 64'd0);
    chk("dw_rmask32", 64'(rm32), 64'hF);
    pop_one();
    xfer(32'h3002, 1'b0, 2, 1'b1, 0, 0, 64'h0000_0000_3333_0002, 1'b0);
    chk("mis_rmask64", 64'(rm64), 64'h3C);
    chk("mis_rmask32", 64'(rm32), 64'hC);
    chk("mis_proto64", 64'(pe64), 64'd1);
    pop_one();

    // reset asserted during a wait state
    xfer(32'h6000, 1'b0, 2, 1'b1, 0, 0, 64'h0000_0000_0000_6000, 1'b0);
    htrans = 2'b10; haddr = 32'h6004; hsize = 3'd2; tag = 1'b1;
    cyc();
    htrans = 2'b00; tag = 1'b0; hready = 1'b0;
    cyc();
    #2;
    rst = 1'b1; exp_stall = 1'b0; exp_pe32 = 1'b0; exp_pe64 = 1'b0;
    idle_bus();
    #1;
    chk("mid_valid32", 64'(v32), 64'd0);
    chk("mid_valid64", 64'(v64), 64'd0);
    chk("mid_state32", 64'(dut32.r_state), 64'(DPH_IDLE));
    chk("mid_proto32", 64'(pe32), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    chk("mid_nopush", 64'(v32), 64'd0);

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahbl_rvfi_mem_monitor.md
AHBL_RVFI_MEM_MONITOR -- requirements
Module: ahbl_rvfi_mem_monitor

Interface
REQ-001 SHALL have parameter W_ADDR, default 32, meaning the bus address width.
REQ-002 SHALL have parameter W_DATA, default 32, meaning the bus data width; legal values are 32 and 64.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the record FIFO depth; it is a power of two and at least 2.
REQ-004 SHALL have parameter MAX_WAIT, default 16, meaning the wait-state count that triggers the timeout flag.
REQ-005 SHALL have port clock, input, width 1: the single clock; all state is rising-edge.
REQ-006 SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-007 SHALL have ports haddr (W_ADDR), hwrite (1), htrans (2), hsize (3), hready (1), hresp (1), hwdata (W_DATA), hrdata (W_DATA), all inputs: the observed AHB-Lite bus.
REQ-008 SHALL have port tag, input, width 1: qualifies the address phase; only tagged transfers are recorded (load/store vs fetch).
REQ-009 SHALL have ports rec_valid (1), rec_addr (W_ADDR), rec_rmask (W_DATA/8), rec_wmask (W_DATA/8), rec_rdata (W_DATA), rec_wdata (W_DATA), rec_err (1), all outputs: the FIFO head record.
REQ-010 SHALL have port rec_pop, input, width 1: consumes the head record.
REQ-011 SHALL have ports overflow (1), stall_timeout (1), proto_err (1), all outputs: sticky status flags.

Function
REQ-012 SHALL capture haddr, hwrite, hsize and (htrans[1] & tag) into data-phase registers on every clock edge where hready=1.
REQ-013 SHALL run a data-phase FSM with states DPH_IDLE, DPH_ACTIVE and DPH_ERR1, evaluated on each edge where hready is sampled.
- Any state -> DPH_ACTIVE when hready=1 and the captured transfer is active.
- Any state -> DPH_IDLE when hready=1 and the captured transfer is not active.
- DPH_ACTIVE -> DPH_ERR1 when hready=0 and hresp=1.
REQ-014 SHALL form the byte mask as (hsize 0:1, 1:3, 2:0xF, 3:0xFF) shifted left by the captured haddr[log2(W_DATA/8)-1:0].
REQ-015 SHALL form rec_addr as the captured haddr with its low log2(W_DATA/8) bits cleared.
REQ-016 SHALL push one record on the final data-phase cycle (DPH_ACTIVE and hready=1).
- Writes: wmask = byte mask, wdata = hwdata, rmask = 0, rdata = 0.
- Reads: rmask = byte mask, rdata = hrdata, wmask = 0, wdata = 0.
REQ-017 SHALL push records with rec_err=1 when the push cycle has hresp=1 and the FSM is in DPH_ERR1; both masks are then zero.
REQ-018 SHALL make the FIFO show-ahead: rec_* reflect the head entry combinationally, and rec_valid=1 whenever the FIFO is non-empty.
REQ-019 SHALL ignore rec_pop while the FIFO is empty.
REQ-020 SHALL, on a push while full with no pop, drop the new record and set overflow.
REQ-021 SHALL, on a simultaneous push and pop while full, accept the push and leave overflow unchanged.
REQ-022 SHALL, on a simultaneous push and pop while empty, push only; rec_valid is 1 on the next cycle.
REQ-023 SHALL count consecutive hready=0 cycles in DPH_ACTIVE or DPH_ERR1 with a saturating counter of width clog2(MAX_WAIT+1); the counter clears on hready=1.
REQ-024 SHALL set stall_timeout when the wait counter reaches MAX_WAIT.
REQ-025 SHALL set proto_err on any of these bus faults:
- hready=0 while in DPH_IDLE;
- hresp=1 with hready=1 outside DPH_ERR1;
- hsize=3 when W_DATA=32;
- an active address phase whose haddr is misaligned to hsize.
REQ-026 SHALL, on a misaligned or illegal-size transfer, still push the record using the computed mask truncated to W_DATA/8 bits.
REQ-027 SHALL keep overflow, stall_timeout and proto_err set until reset.

Reset
REQ-028 SHALL, on reset, immediately force: FIFO empty, rec_valid=0, FSM=DPH_IDLE, wait counter=0, all sticky flags=0, all data-phase registers=0.
REQ-029 SHALL drive rec_addr, rec_rmask, rec_wmask, rec_rdata, rec_wdata and rec_err to 0 while the FIFO is empty.
REQ-030 SHALL, when reset is asserted mid-transfer, discard the in-flight data phase without pushing a record.

Structure
REQ-031 SHALL place HTRANS encodings, HSIZE encodings and the DPH_* state encodings in the shared package hazard5_bus_pkg.
REQ-032 SHALL implement the record FIFO as the sub-module rvfi_rec_fifo, parametrised by width and DEPTH.

Verification
REQ-033 SHALL cover a 32-bit read: NONSEQ read of haddr 0x1002 with hsize=1, tag=1, and one wait state -> one record with rec_addr=0x1000, rmask=0xC, rdata equal to hrdata on the ready cycle.
REQ-034 SHALL cover a 64-bit write: with W_DATA=64, a write of haddr 0x2004 with hsize=2 -> wmask=0xF0, rec_addr=0x2000.
REQ-035 SHALL cover overflow: with DEPTH=4, five tagged transfers and no pop -> four records retained, overflow=1; repeating with pop on the fifth push cycle -> overflow=0.
REQ-036 SHALL cover an error response: hready=0/hresp=1 followed by hready=1/hresp=1 -> a record with rec_err=1 and masks 0; hresp=1 in a single cycle -> proto_err=1.
REQ-037 SHALL cover timeout: with MAX_WAIT=16, 16 consecutive waits -> stall_timeout=1 on the next cycle; with 15 waits -> stall_timeout remains 0.
REQ-038 SHALL cover untagged traffic and mid-transfer reset: an untagged fetch -> no record; reset asserted in the middle of a wait state -> rec_valid=0 and FSM=DPH_IDLE with no clock edge required.
